barrett_reduce_pipe: RTL
========================

Name: barrett_reduce_pipe

Overview:
- Pipelined, stallable Barrett modular reducer: dout = din mod Q for any din < 2^(2*QW).
- Generalises the fixed-modulus combinational reducer:
  - modulus and widths are parameters;
  - intermediate products are kept full-width, with no truncation;
  - two conditional-subtract correction, so the result is fully reduced over the whole input range;
  - valid/ready streaming with a pass-through tag.
- Sits between multiplier datapaths (NTT butterflies, poly-mult) and coefficient storage.

Parameters:
- Q, 829, odd modulus; 3 <= Q < 2^QW.
- QW, 10, modulus width; must satisfy 2^(QW-1) < Q < 2^QW.
- DIN_W, 2*QW-1 (=19), input width; DIN_W <= 2*QW.
- TAG_W, 4, sideband tag width; carried unchanged alongside data.
- MU (localparam), floor(2^(2*QW)/Q) = 1264 for defaults; computed at elaboration.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  din/in_tag valid
- in_ready  out  1  stage can accept this cycle
- din  in  DIN_W  value to reduce
- in_tag  in  TAG_W  sideband, returned with result
- out_valid  out  1  dout/out_tag valid
- out_ready  in  1  downstream accepts
- dout  out  QW  din mod Q, always in [0, Q-1]
- out_tag  out  TAG_W  tag of the input that produced dout

Behaviour:
- Single clock, synchronous active-high reset. In the reset cycle all stage valid bits go to 0; dout, out_tag and internal data registers reset to 0. out_valid=0 and in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight items; nothing is emitted afterwards.
- Pipeline, 3 register stages, each holding a valid bit, data and tag:
  - S1: register a = din, and q1 = din >> QW (QW+1 bits max).
  - S2: t = (q1 * MU) >> QW, full-width product (2*QW+2 bits internal); forward a.
  - S3: r = a - t*Q, computed in QW+2 bits, guaranteed in [0, 3Q-1]. Then if r >= 2Q, dout = r - 2Q; else if r >= Q, dout = r - Q; else dout = r. Register dout and out_tag; out_valid = S3 valid.
- Latency: exactly 3 cycles from an in_valid&&in_ready cycle to out_valid, when not stalled. Throughput is 1 item per cycle.
- Handshake:
  - adv = !out_valid || out_ready; all stages shift together when adv=1.
  - in_ready = adv, purely combinational from out_valid and out_ready.
  - Transfer into S1 occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, all stage registers, dout and out_tag hold stable. in_valid is ignored while in_ready=0.
- Bubbles: in_valid=0 while adv=1 inserts a valid=0 slot. Bubbles advance like data, so there is no compaction.
- Simultaneous events: output accept and input accept in the same cycle are both legal; the pipeline shifts by one. rst has priority over all handshakes.
- Ordering: strictly in-order; out_tag always matches its data.
- Arithmetic: all products and differences are sized to avoid overflow, with no intermediate narrowing to DIN_W. Inputs with din >= 2^(2*QW) are not possible by width.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 -> out_valid=0, dout=0, out_tag=0 during and after; in_ready=1 the cycle after rst drops.
- Directed values, Q=829, no stall, tags 0..4:
  - din=0 -> 0;
  - din=828 -> 828;
  - din=829 -> 0;
  - din=1658 -> 0;
  - din=524287 -> 359 (exercises the double subtract).
  - Each appears exactly 3 cycles after acceptance, with matching tag.
- Back-to-back stream of 1000 random din with out_ready=1 -> one result per cycle after 3-cycle fill; every dout == din % 829; tags in order.
- Backpressure: stream din=829*k+k (k=1..8), with out_ready low for cycles 5-9 -> in_ready=0 exactly while out_valid&&!out_ready; dout/out_tag stable; no loss or duplication; results k in order.
- Reset mid-flight: accept 3 items, assert rst for 1 cycle -> none emitted; the next accepted din=1000 yields 171 after 3 cycles.
- Parameter sweep: Q=3329, QW=12, and Q=257, QW=9, each with random and boundary din (0, Q-1, Q, 2^DIN_W-1) -> dout == din % Q.

Source files
------------

// File: rtl/barrett_reduce_pipe.sv
// Pipelined, stallable Barrett reducer: dout = din mod Q, with a
// valid/ready stream and a tag that travels alongside each value.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake for din/in_tag
//   din, in_tag       value to reduce and its sideband tag
//   out_valid/out_ready downstream handshake for dout/out_tag
//   dout, out_tag     fully reduced result in [0, Q-1] and its tag
module barrett_reduce_pipe #(
  parameter int unsigned Q     = 829,
  parameter int unsigned QW    = 10,
  parameter int unsigned DIN_W = 2*QW-1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] din,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    dout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW = 2*QW+2;
  localparam int unsigned RW = QW+2;

  localparam longint unsigned MU_L =
    (64'd1 << (2*QW)) / 64'(Q);
  localparam logic [QW:0]    MU  = MU_L[QW:0];
  localparam logic [PW-1:0]  Q_P = PW'(Q);
  localparam logic [RW-1:0]  Q1R = RW'(Q);
  localparam logic [RW-1:0]  Q2R = RW'(2*Q);

  logic adv;

  logic             s1_v;
  logic [DIN_W-1:0] s1_a;
  logic [QW:0]      s1_q1;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_v;
  logic [DIN_W-1:0] s2_a;
  logic [RW-1:0]    s2_t;
  logic [TAG_W-1:0] s2_tag;

  logic [PW-1:0] prod;
  logic [RW-1:0] t_nxt;
  logic [PW-1:0] tq;
  logic [PW-1:0] diff;
  logic [RW-1:0] r;
  logic [RW-1:0] red_w;
  logic [QW-1:0] red;

  // Whole pipeline moves as one unit; a held output freezes it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Quotient estimate: t = ((din >> QW) * MU) >> QW, full width.
  assign prod  = PW'(s1_q1) * PW'(MU);
  assign t_nxt = prod[PW-1:QW];

  // Remainder estimate lands in [0, 3Q-1], so the low RW bits
  // of the full-width difference are exact.
  assign tq   = PW'(s2_t) * Q_P;
  assign diff = PW'(s2_a) - tq;
  assign r    = diff[RW-1:0];

  always_comb begin
    red_w = r;
    if (r >= Q2R) begin
      red_w = r - Q2R;
    end else if (r >= Q1R) begin
      red_w = r - Q1R;
    end
  end

  assign red = red_w[QW-1:0];

  logic unused_bits;
  assign unused_bits = ^{prod[QW-1:0],
                         diff[PW-1:RW],
                         red_w[RW-1:QW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_q1     <= '0;
      s1_tag    <= '0;
      s2_v      <= 1'b0;
      s2_a      <= '0;
      s2_t      <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a   <= din;
        s1_q1  <= (QW+1)'(din >> QW);
        s1_tag <= in_tag;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_a   <= s1_a;
        s2_t   <= t_nxt;
        s2_tag <= s1_tag;
      end
      out_valid <= s2_v;
      if (s2_v) begin
        dout    <= red;
        out_tag <= s2_tag;
      end
    end
  end

endmodule
